payload_engine_ctrl: RTL and testbench
======================================

// Module: payload_engine_ctrl
// PURPOSE
//  Sequences a bank of N_ENG payload-match engines (one PCRE rule each, sharing clk/sod/en) across one packet at a time.
//  Per packet: clears engines (sod), gates byte enables (en), flushes the sticky end-state register, snapshots match bits.
//  Reports matching engine IDs to the alert logic one per cycle over a valid/ready handshake, then a done pulse.
//  Sits between the payload byte stream/character decoder and the engine bank.
// PARAMETERS
//  N_ENG      64   number of engines in the bank
//  ID_W       6    width of reported engine ID (>= clog2(N_ENG))
//  FLUSH_CYC  1    extra en cycles issued after last byte (char decode forced to 0)
//  CNT_W      7    width of per-packet match count (holds 0..N_ENG)
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      payload byte beat valid
//  in_sof     in   1      beat is first byte of packet
//  in_eof     in   1      beat is last byte of packet
//  in_ready   out  1      beat accepted when in_valid & in_ready
//  eng_sod    out  1      engine clear (drives engine sod/CLR)
//  eng_en     out  1      engine clock enable (drives engine en)
//  eng_flush  out  1      char decoder must drive all in_* lines to 0
//  eng_match  in   N_ENG  engine out bits, bit i = engine i
//  rpt_valid  out  1      rpt_id valid
//  rpt_ready  in   1      consumer takes rpt_id
//  rpt_id     out  ID_W   index of a matching engine
//  rpt_done   out  1      one-cycle pulse: packet report complete
//  rpt_count  out  CNT_W  matches in packet, valid with rpt_done
//  err_sof    out  1      one-cycle pulse: sof seen mid-packet
// BEHAVIOUR
//  Reset: state IDLE; in_ready, eng_en, eng_flush, rpt_valid, rpt_done, err_sof = 0.
//  Reset: rpt_id, rpt_count, snapshot = 0; eng_sod = 1 while rst high (eng_sod = rst | sod_q).
//  FSM IDLE->CLEAR->SCAN->FLUSH->CAPTURE->REPORT->DONE->IDLE. in_ready combinational from state/flags.
//  IDLE: in_ready=1 for beats without sof (dropped, eng_en=0); in_valid&in_sof -> in_ready=0, go CLEAR.
//  CLEAR: exactly 1 cycle, sod_q=1, in_ready=0, eng_en=0; clears got_first; -> SCAN.
//  SCAN: in_ready=1; eng_en = in_valid&in_ready (same cycle). First accepted beat sets got_first.
//  SCAN: accepted beat with in_eof -> FLUSH (sof&eof single-byte packet legal).
//  SCAN: got_first=1 & in_valid & in_sof: in_ready=0, err_sof pulse, packet discarded (no report), -> CLEAR; sof beat re-accepted after CLEAR.
//  FLUSH: FLUSH_CYC cycles eng_en=1, eng_flush=1, in_ready=0; -> CAPTURE.
//  CAPTURE: 1 cycle, snapshot <= eng_match, count <= popcount; -> REPORT.
//  REPORT: rpt_valid=1 while snapshot!=0; rpt_id = lowest set index. On rpt_valid&rpt_ready clear that bit.
//  REPORT: rpt_id/rpt_valid held stable while rpt_ready=0. Snapshot==0 (incl. no matches) -> DONE.
//  DONE: 1 cycle, rpt_done=1, rpt_count=count; -> IDLE. Engines keep state until next CLEAR.
//  Throughput: 1 byte/cycle in SCAN; report 1 ID/cycle with rpt_ready held high.
//  in_ready=0 in CLEAR/FLUSH/CAPTURE/REPORT/DONE: input backpressured during reporting.
//  rst mid-operation: immediate return to IDLE; eng_sod high clears engines; partial report abandoned, no rpt_done.
// TESTING
//  1 beat sof|eof, eng_match=0 -> eng_sod 1 cycle, eng_en 1+FLUSH_CYC cycles, rpt_done with rpt_count=0, no rpt_valid.
//  10-byte packet, eng_match bits {3,40,63} set at CAPTURE, rpt_ready=1 -> rpt_id 3,40,63 on consecutive cycles; rpt_done count=3.
//  Same packet, rpt_ready toggling 0/1 -> each ID held stable until taken; order 3,40,63; no duplicates/losses.
//  sof at byte 5 of packet -> err_sof pulse, no report for packet 1, CLEAR, new packet scanned and reported normally.
//  rst asserted during REPORT after 1 of 3 IDs taken -> all outputs at reset values next cycle, eng_sod=1, no rpt_done.
//  in_valid gaps inside packet -> eng_en low on gap cycles; N_ENG=64 all bits set -> IDs 0..63 in order, rpt_count=64.

Source files
------------

// File: rtl/payload_engine_ctrl_if.sv
// Handshake bundle between the payload engine controller, the byte stream,
// the engine bank and the alert logic.
interface payload_engine_ctrl_if #(
  parameter int N_ENG = 64,
  parameter int ID_W  = 6,
  parameter int CNT_W = 7
);
  logic             in_valid;
  logic             in_sof;
  logic             in_eof;
  logic             in_ready;
  logic             eng_sod;
  logic             eng_en;
  logic             eng_flush;
  logic [N_ENG-1:0] eng_match;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [ID_W-1:0]  rpt_id;
  logic             rpt_done;
  logic [CNT_W-1:0] rpt_count;
  logic             err_sof;

  modport master (
    input  in_valid, in_sof, in_eof, eng_match, rpt_ready,
    output in_ready, eng_sod, eng_en, eng_flush,
    output rpt_valid, rpt_id, rpt_done, rpt_count, err_sof
  );

  modport slave (
    output in_valid, in_sof, in_eof, eng_match, rpt_ready,
    input  in_ready, eng_sod, eng_en, eng_flush,
    input  rpt_valid, rpt_id, rpt_done, rpt_count, err_sof
  );
endinterface

// File: rtl/payload_engine_ctrl.sv
// Sequences a bank of payload-match engines over one packet at a time and
// reports the matching engine IDs one per cycle, followed by a done pulse.
module payload_engine_ctrl #(
  parameter int N_ENG     = 64,
  parameter int ID_W      = 6,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 7
) (
  input logic                  clk,
  input logic                  rst,
  payload_engine_ctrl_if.master bus
);
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] SCAN    = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] REPORT  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]       state_r;
  logic [2:0]       state_nx_s;
  logic             sod_r;
  logic             got_first_r;
  logic [FC_W-1:0]  flush_cnt_r;
  logic [N_ENG-1:0] snapshot_r;
  logic [CNT_W-1:0] count_r;

  logic in_ready_s;
  logic eng_en_s;
  logic eng_flush_s;
  logic err_sof_s;
  logic rpt_valid_s;
  logic accept_s;
  logic take_s;
  logic flush_last_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [N_ENG-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_ENG; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Scanning downward leaves the lowest set index as the final winner.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_ENG-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = N_ENG - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = ID_W'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  assign flush_last_s = (flush_cnt_r == FC_W'(FLUSH_CYC - 1));
  assign rpt_valid_s  = (state_r == REPORT) && (snapshot_r != '0);
  assign take_s       = rpt_valid_s && bus.rpt_ready;
  assign accept_s     = bus.in_valid && in_ready_s;

  // Per-state input gating, engine strobes and next-state selection.
  always_comb begin
    in_ready_s  = 1'b0;
    eng_en_s    = 1'b0;
    eng_flush_s = 1'b0;
    err_sof_s   = 1'b0;
    state_nx_s  = state_r;
    case (state_r)
      IDLE: begin
        in_ready_s = !(bus.in_valid && bus.in_sof);
        if (bus.in_valid && bus.in_sof) begin
          state_nx_s = CLEAR;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        state_nx_s = SCAN;
      end
      SCAN: begin
        err_sof_s  = got_first_r && bus.in_valid && bus.in_sof;
        in_ready_s = !err_sof_s;
        eng_en_s   = bus.in_valid && in_ready_s;
        if (err_sof_s) begin
          state_nx_s = CLEAR;
        end else if (bus.in_valid && in_ready_s && bus.in_eof) begin
          state_nx_s = FLUSH;
        end else begin
          state_nx_s = SCAN;
        end
      end
      FLUSH: begin
        eng_en_s    = 1'b1;
        eng_flush_s = 1'b1;
        if (flush_last_s) begin
          state_nx_s = CAPTURE;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      CAPTURE: begin
        state_nx_s = REPORT;
      end
      REPORT: begin
        if (snapshot_r == '0) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = REPORT;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state, engine clear strobe, packet flags, flush counter, match snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sod_r       <= 1'b0;
      got_first_r <= 1'b0;
      flush_cnt_r <= '0;
      snapshot_r  <= '0;
      count_r     <= '0;
    end else begin
      state_r <= state_nx_s;
      sod_r   <= (state_nx_s == CLEAR);

      if (state_r == CLEAR) begin
        got_first_r <= 1'b0;
      end else if (state_r == SCAN && accept_s) begin
        got_first_r <= 1'b1;
      end else begin
        got_first_r <= got_first_r;
      end

      if (state_r == FLUSH) begin
        flush_cnt_r <= flush_cnt_r + FC_W'(1);
      end else begin
        flush_cnt_r <= '0;
      end

      // Clearing the lowest set bit retires exactly the ID just handed over.
      if (state_r == CAPTURE) begin
        snapshot_r <= bus.eng_match;
        count_r    <= popcount(bus.eng_match);
      end else if (take_s) begin
        snapshot_r <= snapshot_r & (snapshot_r - N_ENG'(1));
        count_r    <= count_r;
      end else begin
        snapshot_r <= snapshot_r;
        count_r    <= count_r;
      end
    end
  end

  // Strobes are masked while rst is high so reset values appear immediately.
  assign bus.in_ready  = in_ready_s && !rst;
  assign bus.eng_en    = eng_en_s && !rst;
  assign bus.eng_flush = eng_flush_s && !rst;
  assign bus.err_sof   = err_sof_s && !rst;
  assign bus.eng_sod   = rst || sod_r;
  assign bus.rpt_valid = rpt_valid_s;
  assign bus.rpt_id    = lowest_idx(snapshot_r);
  assign bus.rpt_done  = (state_r == DONE);
  assign bus.rpt_count = count_r;
endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Directed self-checking bench for payload_engine_ctrl with hand-computed
// expectations for each packet scenario.
module tb_payload_engine_ctrl;
  logic clk;
  logic rst;

  payload_engine_ctrl_if #(.N_ENG(64), .ID_W(6), .CNT_W(7)) bus ();

  payload_engine_ctrl #(.N_ENG(64), .ID_W(6), .FLUSH_CYC(1), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int sod_n, en_n, flush_n, done_n, err_n, valid_n;
  logic [6:0] done_cnt;
  int ids[$];
  int take_cyc[$];
  int exp_ids[$];
  bit timeout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one packet and monitors the DUT until rpt_done (or rst_after IDs taken).
  task automatic run_pkt(input string name, input int nbytes, input int gap_mod,
                         input logic [63:0] match, input int rdy_mode,
                         input int sof_at, input int rst_after, input int max_cyc);
    int  b;
    int  cyc;
    bit  gap;
    bit  prev_valid, prev_taken;
    int  prev_id;
    sod_n = 0; en_n = 0; flush_n = 0; done_n = 0; err_n = 0; valid_n = 0;
    done_cnt = '0; timeout = 1'b0;
    ids.delete(); take_cyc.delete();
    b = 0; prev_valid = 1'b0; prev_taken = 1'b0; prev_id = 0;
    for (cyc = 0; cyc < max_cyc; cyc++) begin
      @(posedge clk); #1;
      gap = (gap_mod > 0) && ((cyc % gap_mod) == 1) && (b > 0) && (b < nbytes);
      if (b < nbytes && !gap) begin
        bus.in_valid = 1'b1;
        bus.in_sof   = (b == 0) || (b == sof_at);
        bus.in_eof   = (b == nbytes - 1);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
      end
      bus.eng_match = match;
      bus.rpt_ready = (rdy_mode == 1) ? 1'b1 : cyc[0];
      @(negedge clk);
      if (bus.eng_sod)   sod_n++;
      if (bus.eng_en)    en_n++;
      if (bus.eng_flush) flush_n++;
      if (bus.err_sof)   err_n++;
      if (bus.rpt_valid) valid_n++;
      if (gap) chk({name, " gap_en"}, {63'd0, bus.eng_en}, 64'd0);
      if (prev_valid && !prev_taken) begin
        chk({name, " hold_valid"}, {63'd0, bus.rpt_valid}, 64'd1);
        chk({name, " hold_id"}, {58'd0, bus.rpt_id}, prev_id);
      end
      prev_valid = bus.rpt_valid;
      prev_taken = bus.rpt_valid && bus.rpt_ready;
      prev_id    = bus.rpt_id;
      if (bus.in_valid && bus.in_ready) b++;
      if (prev_taken) begin
        ids.push_back(int'(bus.rpt_id));
        take_cyc.push_back(cyc);
      end
      if (bus.rpt_done) begin
        done_n++;
        done_cnt = bus.rpt_count;
        break;
      end
      if (rst_after > 0 && ids.size() == rst_after) break;
    end
    if (cyc >= max_cyc) timeout = 1'b1;
    chk({name, " timeout"}, {63'd0, timeout}, 64'd0);
  endtask

  task automatic chk_ids(input string name);
    chk({name, " id_count"}, ids.size(), exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < ids.size(); i++) begin
      chk({name, " id_order"}, ids[i], exp_ids[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    end
  endtask

  initial begin
    int extra_done;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    bus.eng_match = '0; bus.rpt_ready = 1'b0;
    @(negedge clk);
    chk("rst in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("rst eng_sod",   {63'd0, bus.eng_sod},   64'd1);
    chk("rst eng_en",    {63'd0, bus.eng_en},    64'd0);
    chk("rst rpt_valid", {63'd0, bus.rpt_valid}, 64'd0);
    chk("rst rpt_done",  {63'd0, bus.rpt_done},  64'd0);
    chk("rst rpt_count", {57'd0, bus.rpt_count}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("idle eng_sod",  {63'd0, bus.eng_sod},  64'd0);

    // Single-byte packet, no matches.
    run_pkt("single", 1, 0, 64'd0, 1, -1, 0, 50);
    chk("single sod_n",   sod_n,   1);
    chk("single en_n",    en_n,    2);
    chk("single flush_n", flush_n, 1);
    chk("single valid_n", valid_n, 0);
    chk("single done_n",  done_n,  1);
    chk("single count",   {57'd0, done_cnt}, 64'd0);
    idle(2);

    // Ten bytes, matches on 3, 40, 63, consumer always ready.
    exp_ids = '{3, 40, 63};
    run_pkt("three", 10, 0, (64'd1 << 3) | (64'd1 << 40) | (64'd1 << 63), 1, -1, 0, 100);
    chk_ids("three");
    chk("three en_n",  en_n,  11);
    chk("three sod_n", sod_n, 1);
    chk("three count", {57'd0, done_cnt}, 64'd3);
    if (take_cyc.size() == 3) begin
      chk("three back2back1", take_cyc[1] - take_cyc[0], 1);
      chk("three back2back2", take_cyc[2] - take_cyc[1], 1);
    end
    idle(2);

    // Same packet, consumer toggling ready.
    run_pkt("toggle", 10, 0, (64'd1 << 3) | (64'd1 << 40) | (64'd1 << 63), 0, -1, 0, 100);
    chk_ids("toggle");
    chk("toggle count", {57'd0, done_cnt}, 64'd3);
    idle(2);

    // Restart: sof on byte 5 discards packet 1; bytes 5..9 form packet 2.
    run_pkt("restart", 10, 0, (64'd1 << 3) | (64'd1 << 40) | (64'd1 << 63), 1, 5, 0, 100);
    chk("restart err_n", err_n, 1);
    chk("restart sod_n", sod_n, 2);
    chk("restart en_n",  en_n,  11);
    chk_ids("restart");
    chk("restart count", {57'd0, done_cnt}, 64'd3);
    idle(2);

    // Reset in the middle of REPORT after the first ID is taken.
    run_pkt("midrst", 10, 0, (64'd1 << 3) | (64'd1 << 40) | (64'd1 << 63), 1, -1, 1, 100);
    chk("midrst first_id", ids.size() > 0 ? ids[0] : -1, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_eof = 1'b0;
    @(negedge clk);
    chk("midrst rpt_valid", {63'd0, bus.rpt_valid}, 64'd0);
    chk("midrst rpt_id",    {58'd0, bus.rpt_id},    64'd0);
    chk("midrst rpt_count", {57'd0, bus.rpt_count}, 64'd0);
    chk("midrst eng_sod",   {63'd0, bus.eng_sod},   64'd1);
    chk("midrst in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("midrst eng_en",    {63'd0, bus.eng_en},    64'd0);
    chk("midrst rpt_done",  {63'd0, bus.rpt_done},  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rpt_done || bus.rpt_valid) extra_done++;
    end
    chk("midrst no_report", extra_done, 0);

    // Gapped input, every engine matching.
    exp_ids.delete();
    for (int i = 0; i < 64; i++) exp_ids.push_back(i);
    run_pkt("allmatch", 6, 2, {64{1'b1}}, 1, -1, 0, 200);
    chk("allmatch en_n", en_n, 7);
    chk_ids("allmatch");
    chk("allmatch count", {57'd0, done_cnt}, 64'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
